// File: rtl/debug_cmd_dispatcher_pkg.sv
// Shared constants for the DebugUnit command sequencer: opcodes, response codes,
// owner encoding, FSM states and default widths.
package debug_cmd_dispatcher_pkg;

  localparam int UART_BITS_DEF    = 8;
  localparam int TIMEOUT_BITS_DEF = 24;

  localparam logic [7:0] OP_LOAD      = 8'h01;
  localparam logic [7:0] OP_RUN       = 8'h02;
  localparam logic [7:0] OP_STEP_MODE = 8'h03;

  localparam logic [7:0] ACK_DEF  = 8'hAA;
  localparam logic [7:0] NACK_DEF = 8'hEE;
  localparam logic [7:0] TMO_DEF  = 8'hE1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LOAD = 2'd1,
    OWN_RUN  = 2'd2,
    OWN_STEP = 2'd3
  } owner_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_BUSY,
    ST_SEND_RESP,
    ST_WAIT_RESP
  } state_e;

endpackage

// File: rtl/debug_cmd_dispatcher_watchdog.sv
// Run-mode watchdog: counts enabled cycles, flags expiry at RUN_TIMEOUT-1 and
// saturates there; RUN_TIMEOUT of 0 disables it.
module debug_watchdog #(
  parameter int TIMEOUT_BITS = 24,
  parameter int RUN_TIMEOUT  = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_BITS-1:0] TERMINAL = TIMEOUT_BITS'(RUN_TIMEOUT - 1);
  localparam bit                      ACTIVE   = (RUN_TIMEOUT != 0);

  logic [TIMEOUT_BITS-1:0] r_count;
  logic                    w_at_term;

  assign w_at_term = (r_count == TERMINAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (ACTIVE && enable && !w_at_term) begin
      r_count <= r_count + TIMEOUT_BITS'(1);
    end
  end

  assign expired = ACTIVE && enable && w_at_term;

endmodule

// File: rtl/debug_cmd_dispatcher.sv
// DebugUnit command sequencer: dispatches host opcodes to load/run/step modes,
// hands the UART to the active mode and sends a one-byte status when it ends.
module debug_cmd_dispatcher
  import debug_cmd_dispatcher_pkg::*;
#(
  parameter int                   UART_BITS    = UART_BITS_DEF,
  parameter int                   TIMEOUT_BITS = TIMEOUT_BITS_DEF,
  parameter int                   RUN_TIMEOUT  = 1000000,
  parameter logic [UART_BITS-1:0] ACK_CODE     = UART_BITS'(ACK_DEF),
  parameter logic [UART_BITS-1:0] NACK_CODE    = UART_BITS'(NACK_DEF),
  parameter logic [UART_BITS-1:0] TMO_CODE     = UART_BITS'(TMO_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_done,
  input  logic [UART_BITS-1:0] i_rx_data,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [UART_BITS-1:0] o_tx_data,
  output logic                 o_load_start,
  output logic                 o_run_start,
  output logic                 o_step_start,
  input  logic                 i_load_done,
  input  logic                 i_run_done,
  input  logic                 i_step_done,
  output logic                 o_load_rx_done,
  output logic                 o_run_rx_done,
  output logic                 o_step_rx_done,
  input  logic                 i_load_tx_start,
  input  logic                 i_run_tx_start,
  input  logic                 i_step_tx_start,
  input  logic [UART_BITS-1:0] i_load_tx_data,
  input  logic [UART_BITS-1:0] i_run_tx_data,
  input  logic [UART_BITS-1:0] i_step_tx_data,
  output logic                 o_load_tx_done,
  output logic                 o_run_tx_done,
  output logic                 o_step_tx_done,
  output logic                 o_run_abort,
  output logic [1:0]           o_owner,
  output logic                 o_busy
);

  state_e               r_state, w_state_nxt;
  owner_e               r_owner, w_owner_nxt, w_dec_owner, w_owner_out;
  logic [UART_BITS-1:0] r_opcode;
  logic [UART_BITS-1:0] r_resp, w_resp_nxt;
  logic                 w_owner_done;
  logic                 w_wd_expired;

  debug_watchdog #(
    .TIMEOUT_BITS (TIMEOUT_BITS),
    .RUN_TIMEOUT  (RUN_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state == ST_DISPATCH),
    .enable  ((r_state == ST_BUSY) && (r_owner == OWN_RUN)),
    .expired (w_wd_expired)
  );

  always_comb begin
    w_dec_owner = OWN_NONE;
    if (r_opcode == UART_BITS'(OP_LOAD))      w_dec_owner = OWN_LOAD;
    if (r_opcode == UART_BITS'(OP_RUN))       w_dec_owner = OWN_RUN;
    if (r_opcode == UART_BITS'(OP_STEP_MODE)) w_dec_owner = OWN_STEP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWN_NONE;
      r_resp   <= '0;
      r_opcode <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_resp  <= w_resp_nxt;
      if (r_state == ST_IDLE && i_rx_done) r_opcode <= i_rx_data;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_resp_nxt     = r_resp;
    w_owner_out    = OWN_NONE;
    w_owner_done   = 1'b0;
    o_tx_start     = 1'b0;
    o_tx_data      = '0;
    o_load_start   = 1'b0;
    o_run_start    = 1'b0;
    o_step_start   = 1'b0;
    o_load_rx_done = 1'b0;
    o_run_rx_done  = 1'b0;
    o_step_rx_done = 1'b0;
    o_load_tx_done = 1'b0;
    o_run_tx_done  = 1'b0;
    o_step_tx_done = 1'b0;
    o_run_abort    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_rx_done) w_state_nxt = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (w_dec_owner == OWN_NONE) begin
          w_resp_nxt  = NACK_CODE;
          w_state_nxt = ST_SEND_RESP;
        end else begin
          w_owner_out  = w_dec_owner;
          w_owner_nxt  = w_dec_owner;
          o_load_start = (w_dec_owner == OWN_LOAD);
          o_run_start  = (w_dec_owner == OWN_RUN);
          o_step_start = (w_dec_owner == OWN_STEP);
          w_state_nxt  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_owner_out = r_owner;
        case (r_owner)
          OWN_LOAD: begin
            o_load_rx_done = i_rx_done;
            o_load_tx_done = i_tx_done;
            o_tx_start     = i_load_tx_start;
            o_tx_data      = i_load_tx_data;
            w_owner_done   = i_load_done;
          end
          OWN_RUN: begin
            o_run_rx_done = i_rx_done;
            o_run_tx_done = i_tx_done;
            o_tx_start    = i_run_tx_start;
            o_tx_data     = i_run_tx_data;
            w_owner_done  = i_run_done;
          end
          OWN_STEP: begin
            o_step_rx_done = i_rx_done;
            o_step_tx_done = i_tx_done;
            o_tx_start     = i_step_tx_start;
            o_tx_data      = i_step_tx_data;
            w_owner_done   = i_step_done;
          end
          default: ;
        endcase
        // A completion in the same cycle as expiry is honoured; no abort then.
        if (w_owner_done) begin
          w_resp_nxt  = ACK_CODE;
          w_state_nxt = ST_SEND_RESP;
        end else if (w_wd_expired) begin
          o_run_abort = 1'b1;
          w_resp_nxt  = TMO_CODE;
          w_state_nxt = ST_SEND_RESP;
        end
      end
      ST_SEND_RESP: begin
        o_tx_start  = 1'b1;
        o_tx_data   = r_resp;
        w_owner_nxt = OWN_NONE;
        w_state_nxt = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (i_tx_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_owner = w_owner_out;
  assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_debug_cmd_dispatcher.sv
// Bench for debug_cmd_dispatcher: directed command sequences plus random commands,
// with expected routing and responses computed from the command-level rules.
module tb_debug_cmd_dispatcher;

  localparam int         TO   = 50;
  localparam logic [7:0] ACK  = 8'hAA;
  localparam logic [7:0] NACK = 8'hEE;
  localparam logic [7:0] TMO  = 8'hE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rx_done, i_tx_done;
  logic [7:0] i_rx_data;
  logic [2:0] m_done, m_tx_start;
  logic [7:0] m_tx_data [3];

  logic       o_tx_start, o_run_abort, o_busy;
  logic [7:0] o_tx_data;
  logic [1:0] o_owner;
  logic       o_load_start, o_run_start, o_step_start;
  logic       o_load_rx_done, o_run_rx_done, o_step_rx_done;
  logic       o_load_tx_done, o_run_tx_done, o_step_tx_done;

  logic [2:0]  start_vec, rx_vec, txd_vec;
  logic [21:0] all_out;
  assign start_vec = {o_step_start, o_run_start, o_load_start};
  assign rx_vec    = {o_step_rx_done, o_run_rx_done, o_load_rx_done};
  assign txd_vec   = {o_step_tx_done, o_run_tx_done, o_load_tx_done};
  assign all_out   = {o_tx_start, o_tx_data, start_vec, rx_vec, txd_vec, o_run_abort, o_owner, o_busy};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  debug_cmd_dispatcher #(.UART_BITS(8), .TIMEOUT_BITS(24), .RUN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data), .i_tx_done(i_tx_done),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_load_start(o_load_start), .o_run_start(o_run_start), .o_step_start(o_step_start),
    .i_load_done(m_done[0]), .i_run_done(m_done[1]), .i_step_done(m_done[2]),
    .o_load_rx_done(o_load_rx_done), .o_run_rx_done(o_run_rx_done), .o_step_rx_done(o_step_rx_done),
    .i_load_tx_start(m_tx_start[0]), .i_run_tx_start(m_tx_start[1]), .i_step_tx_start(m_tx_start[2]),
    .i_load_tx_data(m_tx_data[0]), .i_run_tx_data(m_tx_data[1]), .i_step_tx_data(m_tx_data[2]),
    .o_load_tx_done(o_load_tx_done), .o_run_tx_done(o_run_tx_done), .o_step_tx_done(o_step_tx_done),
    .o_run_abort(o_run_abort), .o_owner(o_owner), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    i_rx_done  = 1'b0;
    i_tx_done  = 1'b0;
    m_done     = '0;
    m_tx_start = '0;
  endtask

  task automatic rand_mode_inputs();
    m_tx_start = 3'($urandom);
    for (int j = 0; j < 3; j++) m_tx_data[j] = 8'($urandom);
    i_rx_done = 1'($urandom);
    i_rx_data = 8'($urandom);
  endtask

  // One host command from IDLE back to IDLE. done_k is the BUSY cycle (1-based)
  // in which the owner reports completion; 0 means never.
  task automatic do_cmd(input logic [7:0] op, input int done_k);
    int         ow, idx, k_end, aborts, n_wait;
    logic [7:0] resp;
    logic [2:0] one_hot, exp_start;
    ow    = (op >= 8'd1 && op <= 8'd3) ? int'(op) : 0;
    idx   = (ow == 0) ? 0 : ow - 1;
    k_end = 0;
    if (ow == 0) resp = NACK;
    else if (ow == 2 && (done_k == 0 || done_k > TO)) begin
      resp = TMO; k_end = TO;
    end else begin
      resp = ACK; k_end = done_k;
    end
    one_hot   = 3'b001 << idx;
    exp_start = (ow == 0) ? 3'b000 : one_hot;

    i_rx_done = 1'b1; i_rx_data = op;
    #1 chk("idle_busy", 32'(o_busy), 32'd0);
    cyc();
    i_rx_done = 1'b1; i_rx_data = 8'($urandom);
    #1;
    chk("dispatch_start", 32'(start_vec), 32'(exp_start));
    chk("dispatch_owner", 32'(o_owner), 32'(ow));
    chk("dispatch_rx_drop", 32'(rx_vec), 32'd0);
    cyc();

    aborts = 0;
    for (int k = 1; k <= k_end; k++) begin
      rand_mode_inputs();
      i_tx_done = 1'($urandom);
      m_done    = 3'($urandom) & ~one_hot;
      if (k == done_k) m_done = m_done | one_hot;
      #1;
      chk("busy_owner", 32'(o_owner), 32'(ow));
      chk("busy_tx_start", 32'(o_tx_start), 32'(m_tx_start[idx]));
      chk("busy_tx_data", 32'(o_tx_data), 32'(m_tx_data[idx]));
      chk("busy_rx_route", 32'(rx_vec), 32'(i_rx_done ? one_hot : 3'b000));
      chk("busy_txd_route", 32'(txd_vec), 32'(i_tx_done ? one_hot : 3'b000));
      chk("busy_abort", 32'(o_run_abort), 32'(resp == TMO && k == k_end));
      aborts += int'(o_run_abort);
      cyc();
    end
    if (ow != 0) chk("abort_count", 32'(aborts), 32'(resp == TMO));

    rand_mode_inputs();
    i_rx_done = 1'b1;
    m_done    = 3'b111;
    #1;
    chk("resp_tx_start", 32'(o_tx_start), 32'd1);
    chk("resp_tx_data", 32'(o_tx_data), 32'(resp));
    chk("resp_owner", 32'(o_owner), 32'd0);
    chk("resp_rx_drop", 32'(rx_vec), 32'd0);
    cyc();

    n_wait = $urandom_range(1, 4);
    for (int w = 0; w < n_wait; w++) begin
      rand_mode_inputs();
      m_done = 3'($urandom);
      #1;
      chk("wait_no_tx", 32'(o_tx_start), 32'd0);
      chk("wait_busy", 32'(o_busy), 32'd1);
      chk("wait_gates", 32'({rx_vec, txd_vec}), 32'd0);
      cyc();
    end
    i_tx_done = 1'b1;
    cyc();
    #1 chk("back_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    i_rx_done = 1'b0; i_tx_done = 1'b0; i_rx_data = '0;
    m_done = '0; m_tx_start = 3'b111;
    for (int j = 0; j < 3; j++) m_tx_data[j] = 8'h3C;
    #3 chk("reset_outputs", 32'(all_out), 32'd0);
    cyc(); cyc();
    rst = 1'b1;

    do_cmd(8'h01, 20);
    do_cmd(8'h02, 0);
    do_cmd(8'h03, 15);
    do_cmd(8'h09, 0);
    do_cmd(8'h05, 0);
    do_cmd(8'h02, TO);
    do_cmd(8'h02, TO - 1);

    // Reset mid-command while step mode owns the UART
    i_rx_done = 1'b1; i_rx_data = 8'h03;
    cyc(); cyc();
    for (int b = 0; b < 3; b++) begin
      i_rx_done = 1'b1;
      i_rx_data = (b == 2) ? 8'h05 : 8'h04;
      #1 chk("step_rx_only", 32'(rx_vec), 32'b100);
      cyc();
    end
    m_tx_start = 3'b111; m_tx_data[2] = 8'h5A; i_rx_done = 1'b1; i_tx_done = 1'b1;
    #1 chk("pre_reset_tx", 32'(o_tx_data), 32'h5A);
    rst = 1'b0;
    #1 chk("mid_reset_outputs", 32'(all_out), 32'd0);
    cyc();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("post_reset_quiet", 32'({o_tx_start, o_busy}), 32'd0);
      cyc();
    end
    do_cmd(8'h01, 5);

    for (int r = 0; r < 15; r++) begin
      logic [7:0] op;
      op = 8'($urandom_range(0, 7));
      do_cmd(op, (op == 8'h02) ? $urandom_range(40, 60) : $urandom_range(1, 25));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
